mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, line address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width.
REQ-003 SHALL have ports clk (input, 1, clock) and reset (input, 1, reset); reset is synchronous, active-high; clock is clk.
REQ-004 SHALL have icache-side ports: i_req (in, 1, read request level), i_addr (in, ADDR_W, line address), i_data (out, LINE_W, read line), i_ready (out, 1, one-cycle done pulse).
REQ-005 SHALL have dcache read ports: d_req (in, 1, read request level), d_addr (in, ADDR_W, line address), d_data (out, LINE_W, read line), d_ready (out, 1, done pulse).
REQ-006 SHALL have dcache write ports: d_wreq (in, 1, write-back request level), d_waddr (in, ADDR_W, line address), d_wdata (in, LINE_W, line data), d_wack (out, 1, done pulse).
REQ-007 SHALL have memory ports: m_req (out, 1), m_we (out, 1), m_addr (out, ADDR_W), m_wdata (out, LINE_W), m_rdata (in, LINE_W), m_ack (in, 1, transfer complete).
REQ-008 SHALL have i_stall and d_stall (out, 1 each): high while that requester's request is pending and not yet done.

Function
REQ-009 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-010 IDLE: on any request, SHALL latch winner, address, write data and m_we; next state BUSY.
REQ-011 Fixed priority SHALL be d_wreq > d_req > i_req.
REQ-012 BUSY: m_req, m_we, m_addr, m_wdata SHALL be driven from the latched values and held stable until m_ack.
REQ-013 On m_ack in BUSY, SHALL capture m_rdata into the winner's data register; next state DONE.
REQ-014 DONE: SHALL pulse exactly one of i_ready / d_ready / d_wack for one cycle, with m_req low; next state IDLE.
REQ-015 Requests SHALL NOT be sampled in DONE; a requester drops its request in the DONE cycle.
REQ-016 Latency SHALL be request to m_req = 1 cycle; m_ack to done pulse = 1 cycle.
REQ-017 i_data and d_data SHALL hold their last captured line until the next read for that requester completes.
REQ-018 Request deasserted during BUSY SHALL NOT abort the transfer; completion still pulses.
REQ-019 m_ack outside BUSY SHALL be ignored.
REQ-020 Simultaneous d_wreq and d_req SHALL serve the write first; the read is served on the next IDLE.

Reset
REQ-021 Reset SHALL force IDLE; m_req, m_we, i_ready, d_ready, d_wack = 0; m_addr, m_wdata, i_data, d_data = 0.
REQ-022 Reset during BUSY SHALL drop m_req the next cycle and produce no done pulse.

Configuration
REQ-023 With MEM_ARB_RR_EN defined, the icache vs dcache choice SHALL be round-robin: a last-grant bit favours the other side; d_wreq still beats d_req within the dcache side.
REQ-024 Without MEM_ARB_RR_EN, fixed priority per REQ-011 SHALL apply and no last-grant state SHALL exist.
REQ-025 The last-grant bit SHALL reset to 'icache granted last', so the dcache wins the first tie.

Structure
REQ-026 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY, DONE), the owner enum (OWN_I, OWN_DR, OWN_DW) and default widths.
REQ-027 Grant selection SHALL be a sub-module mem_arb_grant (combinational, RR bit input); everything else stays in mem_arbiter.

Verification
REQ-028 i_req, i_addr=0x000010, m_ack 3 cycles after m_req, m_rdata=0xA5..A5 -> m_req one cycle after request, i_ready one cycle after m_ack, i_data=0xA5..A5.
REQ-029 d_wreq (addr 0x20, data 0x1234) and d_req (addr 0x40) same cycle -> write (m_we=1) first, d_wack; then read, d_ready.
REQ-030 i_req and d_req held together for 4 transfers -> fixed: all D before I; MEM_ARB_RR_EN: D,I,D,I.
REQ-031 reset asserted mid-BUSY -> m_req=0 next cycle, no done pulse; a later m_ack is ignored.
REQ-032 m_ack pulsed in IDLE with no request -> no state change, no pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings and default widths for the memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {OWN_I, OWN_DR, OWN_DW} owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select: d_wreq > d_req > i_req, or round-robin icache vs dcache
// when MEM_ARB_RR_EN is defined (d_wreq still beats d_req inside the dcache side).
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       d_wreq,
    input  logic       last_i,
    output logic       any_req,
    output logic [1:0] owner
);

    logic d_side;

    assign any_req = i_req | d_req | d_wreq;

`ifdef MEM_ARB_RR_EN
    // last_i set means the icache won the previous grant, so a tie goes to the dcache
    assign d_side = (d_req | d_wreq) & (~i_req | last_i);
`else
    logic unused_last_i;
    assign unused_last_i = last_i;
    assign d_side        = d_req | d_wreq;
`endif

    always_comb begin
        owner = OWN_I;
        if (d_side) begin
            owner = d_wreq ? OWN_DW : OWN_DR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for icache reads, dcache reads and dcache write-backs.
// Request to m_req 1 cycle, m_ack to done pulse 1 cycle; MEM_ARB_RR_EN enables round-robin I/D.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_data,
    output logic              i_ready,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [LINE_W-1:0] d_data,
    output logic              d_ready,
    input  logic              d_wreq,
    input  logic [ADDR_W-1:0] d_waddr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_wack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              i_stall,
    output logic              d_stall
);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner_q;
    logic              we_q;
    logic              latch;
    logic              any_req;
    logic              last_i;
    logic [1:0]        grant_owner;
    logic [ADDR_W-1:0] sel_addr;

    mem_arb_grant u_grant (
        .i_req   (i_req),
        .d_req   (d_req),
        .d_wreq  (d_wreq),
        .last_i  (last_i),
        .any_req (any_req),
        .owner   (grant_owner)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_i <= 1'b1;
        end else if (latch) begin
            last_i <= (grant_owner == OWN_I);
        end
    end
`else
    assign last_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        m_req     = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        d_wack    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    latch     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_req = 1'b1;
                if (m_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                i_ready   = (owner_q == OWN_I);
                d_ready   = (owner_q == OWN_DR);
                d_wack    = (owner_q == OWN_DW);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_addr = d_waddr;
        if (grant_owner == OWN_I) begin
            sel_addr = i_addr;
        end else if (grant_owner == OWN_DR) begin
            sel_addr = d_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_data  <= '0;
            d_data  <= '0;
        end else begin
            if (latch) begin
                owner_q <= owner_t'(grant_owner);
                we_q    <= (grant_owner == OWN_DW);
                m_addr  <= sel_addr;
                m_wdata <= d_wdata;
            end
            // only a read owner keeps the returned line; write acks leave both lines untouched
            if (state == BUSY && m_ack) begin
                if (owner_q == OWN_I) begin
                    i_data <= m_rdata;
                end else if (owner_q == OWN_DR) begin
                    d_data <= m_rdata;
                end
            end
        end
    end

    assign m_we    = m_req & we_q;
    assign i_stall = i_req & ~i_ready;
    assign d_stall = (d_req & ~d_ready) | (d_wreq & ~d_wack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters plan their service order from the arbitration rules,
// a memory responder answers with random latency, and a monitor checks every transfer and done pulse.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 26;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_wreq;
    logic [AW-1:0] i_addr, d_addr, d_waddr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] i_data, d_data;
    logic          i_ready, d_ready, d_wack;
    logic          m_req, m_we, m_ack;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_rdata;
    logic          i_stall, d_stall;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_data  (d_data),
        .d_ready (d_ready),
        .d_wreq  (d_wreq),
        .d_waddr (d_waddr),
        .d_wdata (d_wdata),
        .d_wack  (d_wack),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .i_stall (i_stall),
        .d_stall (d_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        owner_t        own;
        logic [AW-1:0] addr;
        logic          we;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            model_last_i = 1'b1;
    logic [AW-1:0] ia[4], dra[4], dwa[4];
    logic [LW-1:0] dwd[4];
    int            rsp_dly = -1;
    bit            ack_hold = 1'b0;
    bit            stray_en = 1'b0;
    bit            stray_req = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Memory contents as seen by reads; line 0x10 is the all-A5 pattern.
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == 26'h10) return {16{8'hA5}};
        h = {6'b0, a} * 32'h9E37_79B9;
        return {h, ~h, h ^ 32'h5A5A_C3C3, h + 32'd7};
    endfunction

    function automatic logic done_of(input int which);
        case (which)
            0:       return i_ready;
            1:       return d_ready;
            default: return d_wack;
        endcase
    endfunction

    // Reference order: requesters with work left are all pending at each grant.
    task automatic plan(input int ni, input int ndr, input int ndw);
        int   ci, cr, cw;
        bit   want_i, want_d, pick_d;
        exp_t e;
        ci = 0; cr = 0; cw = 0;
        while (ci < ni || cr < ndr || cw < ndw) begin
            want_i = (ci < ni);
            want_d = (cr < ndr) || (cw < ndw);
`ifdef MEM_ARB_RR_EN
            pick_d = want_d && (!want_i || model_last_i);
`else
            pick_d = want_d;
`endif
            if (pick_d && cw < ndw) begin
                e.own = OWN_DW; e.addr = dwa[cw]; e.we = 1'b1; e.wdata = dwd[cw]; e.rdata = '0;
                cw++;
            end else if (pick_d) begin
                e.own = OWN_DR; e.addr = dra[cr]; e.we = 1'b0; e.wdata = '0; e.rdata = line_of(dra[cr]);
                cr++;
            end else begin
                e.own = OWN_I; e.addr = ia[ci]; e.we = 1'b0; e.wdata = '0; e.rdata = line_of(ia[ci]);
                ci++;
            end
            model_last_i = !pick_d;
            exp_q.push_back(e);
        end
    endtask

    // One requester: raise, wait for its done pulse, drop in the done cycle, re-raise next cycle.
    task automatic drive(input int which, input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            case (which)
                0:       begin i_addr = ia[k]; i_req = 1'b1; end
                1:       begin d_addr = dra[k]; d_req = 1'b1; end
                default: begin d_waddr = dwa[k]; d_wdata = dwd[k]; d_wreq = 1'b1; end
            endcase
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!done_of(which) && t < 100);
            checks++;
            if (!done_of(which)) begin
                errors++;
                $display("FAIL req%0d_timeout: no done pulse after %0d cycles, required one", which, t);
            end
            case (which)
                0:       i_req = 1'b0;
                1:       d_req = 1'b0;
                default: d_wreq = 1'b0;
            endcase
        end
    endtask

    task automatic run_round(input int ni, input int ndr, input int ndw);
        plan(ni, ndr, ndw);
        fork
            drive(0, ni);
            drive(1, ndr);
            drive(2, ndw);
        join
        repeat (2) @(negedge clk);
    endtask

    // Memory responder
    initial begin
        bit in_xfer = 1'b0;
        int cnt = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (reset) begin
                in_xfer = 1'b0;
            end else if (m_req) begin
                if (!in_xfer) begin
                    in_xfer = 1'b1;
                    cnt = (rsp_dly >= 0) ? rsp_dly : int'($urandom_range(0, 3));
                end
                if (!ack_hold) begin
                    if (cnt == 0) begin
                        m_ack = 1'b1;
                        m_rdata = line_of(m_addr);
                        in_xfer = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end else if (stray_req || (stray_en && $urandom_range(0, 3) == 0)) begin
                m_ack = 1'b1;
                m_rdata = {4{32'hDEAD_BEEF}};
                stray_req = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        bit            prev_mreq = 1'b0;
        logic [AW-1:0] h_addr = '0;
        logic          h_we = 1'b0;
        logic [LW-1:0] h_wdata = '0;
        logic [LW-1:0] last_i = '0;
        logic [LW-1:0] last_d = '0;
        int            np;
        exp_t          e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_mreq = 1'b0;
                last_i = '0;
                last_d = '0;
                continue;
            end
            if (m_req && !prev_mreq) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_start: m_req raised for addr %h, required no transfer", m_addr);
                end else begin
                    e = exp_q[0];
                    check("xfer_addr", m_addr, e.addr);
                    check("xfer_we", m_we, e.we);
                    if (e.we) check("xfer_wdata", m_wdata, e.wdata);
                end
                h_addr = m_addr; h_we = m_we; h_wdata = m_wdata;
            end else if (m_req) begin
                check("xfer_hold_addr_we", {m_addr, m_we}, {h_addr, h_we});
                check("xfer_hold_wdata", m_wdata, h_wdata);
            end
            np = int'(i_ready) + int'(d_ready) + int'(d_wack);
            if (np != 0) begin
                check("done_one_hot", np, 1);
                check("done_mreq_low", m_req, 0);
                check("done_after_ack", {prev_mreq, m_ack}, 2'b11);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: pulses i/dr/dw=%b, required none", {i_ready, d_ready, d_wack});
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", {i_ready, d_ready, d_wack},
                          (e.own == OWN_I) ? 3'b100 : (e.own == OWN_DR) ? 3'b010 : 3'b001);
                    if (e.own == OWN_I) last_i = e.rdata;
                    else if (e.own == OWN_DR) last_d = e.rdata;
                    check("i_data", i_data, last_i);
                    check("d_data", d_data, last_d);
                end
            end
            prev_mreq = m_req;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int ni, nr, nw;
        i_req = 1'b0; d_req = 1'b0; d_wreq = 1'b0;
        i_addr = '0; d_addr = '0; d_waddr = '0; d_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_pulses", {i_ready, d_ready, d_wack}, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_i_data", i_data, 0);
        check("rst_d_data", d_data, 0);
        check("rst_stalls", {i_stall, d_stall}, 0);
        reset = 1'b0;

        // icache read of line 0x10, memory acks 3 cycles after m_req
        rsp_dly = 3;
        ia[0] = 26'h10;
        plan(1, 0, 0);
        @(negedge clk);
        i_addr = ia[0]; i_req = 1'b1;
        @(negedge clk);
        check("req_to_mreq", m_req, 1);
        check("i_stall_busy", i_stall, 1);
        t = 1;
        while (!i_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        // 1 cycle to m_req, 3 cycles to m_ack, 1 cycle to i_ready
        check("req_to_iready_cycles", t, 5);
        check("i_data_a5", i_data, {16{8'hA5}});
        check("i_stall_done", i_stall, 0);
        i_req = 1'b0;
        rsp_dly = -1;
        repeat (2) @(negedge clk);

        // simultaneous write-back and read: write first
        dwa[0] = 26'h20; dwd[0] = 128'h1234; dra[0] = 26'h40;
        run_round(0, 1, 1);

        // stray m_ack while idle
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_ack_no_mreq", m_req, 0);

        // reset in the middle of a transfer
        ack_hold = 1'b1;
        ia[0] = 26'h30;
        plan(1, 0, 0);
        @(negedge clk);
        i_addr = ia[0]; i_req = 1'b1;
        @(negedge clk);
        check("busy_before_reset", m_req, 1);
        @(negedge clk);
        reset = 1'b1; i_req = 1'b0;
        @(negedge clk);
        check("reset_drops_mreq", m_req, 0);
        check("reset_no_pulse", {i_ready, d_ready, d_wack}, 0);
        reset = 1'b0;
        exp_q.delete();
        model_last_i = 1'b1;
        ack_hold = 1'b0;
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        check("late_ack_ignored", m_req, 0);
        check("reset_cleared_i_data", i_data, 0);

        // icache and dcache reads contending for four transfers
        ia[0] = 26'h100; ia[1] = 26'h104; dra[0] = 26'h200; dra[1] = 26'h204;
        run_round(2, 2, 0);

        // randomized rounds with stray acks outside transfers
        stray_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            ni = int'($urandom_range(0, 3));
            nr = int'($urandom_range(0, 3));
            nw = int'($urandom_range(0, 3));
            if (ni + nr + nw == 0) ni = 1;
            for (int k = 0; k < 4; k++) begin
                ia[k]  = AW'($urandom);
                dra[k] = AW'($urandom);
                dwa[k] = AW'($urandom);
                dwd[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            run_round(ni, nr, nw);
        end
        stray_en = 1'b0;
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
